// File: rtl/hazard_pkg.sv
// Shared constants and helpers for the forwarding / hazard unit.
package hazard_pkg;

  localparam int REG_AW_DEF  = 5;
  localparam int NUM_STG_DEF = 2;
  localparam int FWD_RF      = 0;

  // Stage k is selected by code k+1; code 0 is the register file.
  function automatic int stg_sel(input int k);
    return k + 1;
  endfunction

endpackage

// File: rtl/fwd_src_select.sv
// Resolves one source operand against the scoreboard and the
// forwarding stages, youngest matching stage first.
module fwd_src_select
  import hazard_pkg::*;
#(
  parameter int REG_AW  = REG_AW_DEF,
  parameter int NUM_STG = NUM_STG_DEF,
  parameter int SEL_W   = $clog2(NUM_STG + 1)
) (
  input  logic [REG_AW-1:0]         addr,
  input  logic                      used,
  input  logic                      busy,
  input  logic [NUM_STG-1:0]        wb_en,
  input  logic [NUM_STG*REG_AW-1:0] rd,
  input  logic [NUM_STG-1:0]        rdy,
  output logic [SEL_W-1:0]          sel,
  output logic                      stall
);

  logic [NUM_STG-1:0] hit;

  always_comb begin
    hit = '0;
    for (int k = 0; k < NUM_STG; k++) begin
      hit[k] = wb_en[k]
             && (rd[k*REG_AW +: REG_AW] == addr)
             && (rd[k*REG_AW +: REG_AW] != '0);
    end
  end

  // Descending scan: the last assignment is the youngest hit.
  always_comb begin
    sel   = SEL_W'(FWD_RF);
    stall = 1'b0;
    if (used && (addr != '0)) begin
      if (busy) begin
        stall = 1'b1;
      end else begin
        for (int k = NUM_STG - 1; k >= 0; k--) begin
          if (hit[k]) begin
            sel   = SEL_W'(stg_sel(k));
            stall = !rdy[k];
          end
        end
      end
    end
  end

endmodule

// File: rtl/scoreboard_forward_unit.sv
// Forwarding mux control, long-latency scoreboard, pipeline stall
// and saturating stall-cycle counter for the EX stage.
module scoreboard_forward_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW  = REG_AW_DEF,
  parameter int NUM_SRC = 2,
  parameter int NUM_STG = NUM_STG_DEF,
  parameter int LAT_W   = 3,
  parameter int SEL_W   = $clog2(NUM_STG + 1),
  parameter int PERF_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC*REG_AW-1:0] src_addr,
  input  logic [NUM_SRC-1:0]        src_used,
  input  logic [NUM_STG-1:0]        stg_wb_en,
  input  logic [NUM_STG*REG_AW-1:0] stg_rd,
  input  logic [NUM_STG-1:0]        stg_rdy,
  input  logic                      issue_valid,
  input  logic [REG_AW-1:0]         issue_rd,
  input  logic [LAT_W-1:0]          issue_lat,
  output logic [NUM_SRC*SEL_W-1:0]  fwd_sel,
  output logic                      stall,
  output logic [NUM_SRC-1:0]        stall_src,
  output logic [PERF_W-1:0]         stall_cycles
);

  localparam int NREG = 2 ** REG_AW;

  logic [LAT_W-1:0] cnt [1:NREG-1];
  logic [NREG-1:0]  busy;
  logic [LAT_W-1:0] lat_ld;

  always_comb begin
    lat_ld = issue_lat;
    unique case (1'b1)
      (issue_lat == '0): lat_ld = LAT_W'(1);
      default:           lat_ld = issue_lat;
    endcase
  end

  always_comb begin
    busy = '0;
    for (int r = 1; r < NREG; r++) begin
      busy[r] = (cnt[r] != '0);
    end
  end

  // A fresh issue wins over the decrement of the same entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 1; r < NREG; r++) begin
        cnt[r] <= '0;
      end
    end else begin
      for (int r = 1; r < NREG; r++) begin
        if (issue_valid && (issue_rd == REG_AW'(r))) begin
          cnt[r] <= lat_ld;
        end else if (cnt[r] != '0) begin
          cnt[r] <= cnt[r] - LAT_W'(1);
        end
      end
    end
  end

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    logic [REG_AW-1:0] a;
    logic              u;
    assign a = src_addr[i*REG_AW +: REG_AW];
    assign u = src_used[i] & ~rst;

    fwd_src_select #(
      .REG_AW  (REG_AW),
      .NUM_STG (NUM_STG),
      .SEL_W   (SEL_W)
    ) u_sel (
      .addr  (a),
      .used  (u),
      .busy  (busy[a]),
      .wb_en (stg_wb_en),
      .rd    (stg_rd),
      .rdy   (stg_rdy),
      .sel   (fwd_sel[i*SEL_W +: SEL_W]),
      .stall (stall_src[i])
    );
  end

  assign stall = |stall_src;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (stall && !(&stall_cycles)) begin
      stall_cycles <= stall_cycles + PERF_W'(1);
    end
  end

endmodule
